// File: rtl/ibex_fetch_req_ctrl.sv
// Fetch request sequencer between the instruction bus and the prefetch FIFO.
// Issues word-aligned requests, tracks up to NUM_REQS outstanding responses,
// discards responses made stale by branches and tags pushes with PCC errors.
// Ports:
//   clk_i, rst_ni                : clock, async active-low reset
//   req_i, branch_i, addr_i      : fetch enable, redirect pulse and target
//   busy_o                       : request held or responses outstanding
//   pcc_base_i, pcc_top_i        : PCC bounds [base, top)
//   instr_*                      : instruction bus request/response
//   fifo_busy_i                  : FIFO upper-entry occupancy
//   fifo_*_o                     : FIFO clear/push interface
module ibex_fetch_req_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  input  logic [31:0]         pcc_base_i,
  input  logic [32:0]         pcc_top_i,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                fifo_cheri_lower_err_o,
  output logic                fifo_cheri_upper_err_o
);

  localparam int unsigned CW = $clog2(NUM_REQS + 1);
  localparam int unsigned SW = $clog2(2 * NUM_REQS + 2);
  localparam int unsigned PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  typedef enum logic {IDLE = 1'b0, WAIT_GNT = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [31:0]         fetch_addr_q, fetch_addr_d, req_addr_q, branch_tgt;
  logic                stale_q, stale_d, load_req;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [NUM_REQS-1:0] disc_q, lerr_q, uerr_q;
  logic [SW-1:0]       occ_upper, occ_eff;
  logic                issue_idle, issue_wait, gnt_fire, rvalid, gnt_disc;
  logic                lower_err, upper_err;
  logic [32:0]         a_ext, base_ext;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_REQS - 1)) ? '0 : p + PW'(1);
  endfunction

  assign branch_tgt = {addr_i[31:2], 2'b00};

  // Occupied FIFO upper entries; ignored while the FIFO is being cleared.
  always_comb begin
    occ_upper = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      occ_upper = occ_upper + SW'(fifo_busy_i[i]);
    end
  end
  assign occ_eff = branch_i ? '0 : occ_upper;

  assign issue_idle = req_i & ((occ_eff + SW'(cnt_q)) < SW'(NUM_REQS));
  // Re-issue straight after a grant must leave room for the one being granted.
  assign issue_wait = req_i & ((occ_eff + SW'(cnt_q) + SW'(1)) < SW'(NUM_REQS));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (issue_idle && !instr_gnt_i) state_d = WAIT_GNT;
      WAIT_GNT: if (instr_gnt_i) state_d = issue_wait ? WAIT_GNT : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Bus request outputs; a held request keeps its address until granted.
  always_comb begin
    instr_req_o  = 1'b0;
    instr_addr_o = branch_i ? branch_tgt : fetch_addr_q;
    busy_o       = (cnt_q != '0);
    case (state_q)
      IDLE:     instr_req_o = issue_idle;
      WAIT_GNT: begin
        instr_req_o  = 1'b1;
        instr_addr_o = req_addr_q;
        busy_o       = 1'b1;
      end
      default: ;
    endcase
  end

  assign gnt_fire = instr_req_o & instr_gnt_i;
  assign rvalid   = instr_rvalid_i & (cnt_q != '0);
  // A held request is stale if a branch arrived while it waited (or now).
  assign gnt_disc = (state_q == WAIT_GNT) & (stale_q | branch_i);

  // PCC checks on the granted word, 33-bit so the top never wraps.
  assign a_ext     = {1'b0, instr_addr_o};
  assign base_ext  = {1'b0, pcc_base_i};
  assign lower_err = (a_ext < base_ext) | ((a_ext + 33'd2) > pcc_top_i);
  assign upper_err = ((a_ext + 33'd2) < base_ext) | ((a_ext + 33'd4) > pcc_top_i);

  // Fetch address, stale tracking and outstanding count.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (state_q == IDLE) begin
      if (gnt_fire)      fetch_addr_d = instr_addr_o + 32'd4;
      else if (branch_i) fetch_addr_d = branch_tgt;
    end else begin
      if (branch_i)                fetch_addr_d = branch_tgt;
      else if (gnt_fire && !stale_q) fetch_addr_d = fetch_addr_q + 32'd4;
    end

    stale_d  = (state_q == WAIT_GNT && !gnt_fire) ? (stale_q | branch_i) : 1'b0;
    load_req = (state_d == WAIT_GNT) && ((state_q == IDLE) || gnt_fire);

    cnt_d = cnt_q;
    case ({gnt_fire, rvalid})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
  end

  // Datapath registers and outstanding-response queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_addr_q <= '0;
      req_addr_q   <= '0;
      stale_q      <= 1'b0;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      disc_q       <= '0;
      lerr_q       <= '0;
      uerr_q       <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      stale_q      <= stale_d;
      cnt_q        <= cnt_d;
      if (load_req) req_addr_q <= fetch_addr_d;
      if (branch_i) disc_q <= '1;
      if (gnt_fire) begin
        disc_q[wr_ptr_q] <= gnt_disc;
        lerr_q[wr_ptr_q] <= lower_err;
        uerr_q[wr_ptr_q] <= upper_err;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (rvalid) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // FIFO interface; payload is zeroed when nothing is pushed.
  assign fifo_clear_o           = branch_i;
  assign fifo_addr_o            = addr_i;
  assign fifo_valid_o           = rvalid & ~disc_q[rd_ptr_q] & ~branch_i;
  assign fifo_rdata_o           = fifo_valid_o ? instr_rdata_i : '0;
  assign fifo_err_o             = fifo_valid_o & instr_err_i;
  assign fifo_cheri_lower_err_o = fifo_valid_o & lerr_q[rd_ptr_q];
  assign fifo_cheri_upper_err_o = fifo_valid_o & uerr_q[rd_ptr_q];

  a_rvalid_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> (cnt_q != '0));
  a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CW'(NUM_REQS));

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
module tb_ibex_fetch_req_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, branch_i;
  logic [31:0] addr_i;
  logic        busy_o;
  logic [31:0] pcc_base_i;
  logic [32:0] pcc_top_i;
  logic        instr_req_o, instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic [1:0]  fifo_busy_i;
  logic        fifo_clear_o, fifo_valid_o;
  logic [31:0] fifo_addr_o, fifo_rdata_o;
  logic        fifo_err_o, fifo_cheri_lower_err_o, fifo_cheri_upper_err_o;

  int passed = 0;
  int total  = 0;

  ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .busy_o(busy_o), .pcc_base_i(pcc_base_i), .pcc_top_i(pcc_top_i),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .fifo_busy_i(fifo_busy_i), .fifo_clear_o(fifo_clear_o), .fifo_valid_o(fifo_valid_o),
    .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o), .fifo_err_o(fifo_err_o),
    .fifo_cheri_lower_err_o(fifo_cheri_lower_err_o),
    .fifo_cheri_upper_err_o(fifo_cheri_upper_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_i = 1'b0; branch_i = 1'b0; addr_i = '0;
    pcc_base_i = '0; pcc_top_i = 33'h1_0000_0000;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
    fifo_busy_i = '0;
    tick(); tick();
    total++; if (instr_req_o !== 1'b0) $display("FAIL reset_req got %b exp 0", instr_req_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_o); else passed++;
    total++; if (instr_addr_o !== 32'h0) $display("FAIL reset_addr got %h exp 0", instr_addr_o); else passed++;
    total++; if (fifo_valid_o !== 1'b0 || fifo_clear_o !== 1'b0) $display("FAIL reset_fifo got v=%b c=%b exp 0 0", fifo_valid_o, fifo_clear_o); else passed++;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic_fetch();
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h80; instr_gnt_i = 1'b1;
    settle();
    total++; if (fifo_clear_o !== 1'b1 || fifo_addr_o !== 32'h80) $display("FAIL basic_clear got c=%b a=%h exp 1 00000080", fifo_clear_o, fifo_addr_o); else passed++;
    total++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80) $display("FAIL basic_addr0 got r=%b a=%h exp 1 00000080", instr_req_o, instr_addr_o); else passed++;
    tick();
    branch_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hD000_0080;
    settle();
    total++; if (instr_addr_o !== 32'h84) $display("FAIL basic_addr1 got %h exp 00000084", instr_addr_o); else passed++;
    total++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== 32'hD000_0080) $display("FAIL basic_push0 got v=%b d=%h exp 1 d0000080", fifo_valid_o, fifo_rdata_o); else passed++;
    tick();
    instr_rdata_i = 32'hD000_0084;
    settle();
    total++; if (instr_addr_o !== 32'h88) $display("FAIL basic_addr2 got %h exp 00000088", instr_addr_o); else passed++;
    total++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== 32'hD000_0084) $display("FAIL basic_push1 got v=%b d=%h exp 1 d0000084", fifo_valid_o, fifo_rdata_o); else passed++;
    tick();
    req_i = 1'b0; instr_gnt_i = 1'b0; instr_rdata_i = 32'hD000_0088;
    settle();
    total++; if (instr_req_o !== 1'b0) $display("FAIL basic_req_off got %b exp 0", instr_req_o); else passed++;
    total++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== 32'hD000_0088) $display("FAIL basic_push2 got v=%b d=%h exp 1 d0000088", fifo_valid_o, fifo_rdata_o); else passed++;
    tick();
    instr_rvalid_i = 1'b0;
    settle();
    total++; if (busy_o !== 1'b0 || fifo_valid_o !== 1'b0) $display("FAIL basic_drain got b=%b v=%b exp 0 0", busy_o, fifo_valid_o); else passed++;
  endtask

  task automatic test_throttle();
    fifo_busy_i = 2'b11; req_i = 1'b1; instr_gnt_i = 1'b0;
    settle();
    total++; if (instr_req_o !== 1'b0) $display("FAIL throttle_full0 got %b exp 0", instr_req_o); else passed++;
    tick();
    total++; if (instr_req_o !== 1'b0) $display("FAIL throttle_full1 got %b exp 0", instr_req_o); else passed++;
    fifo_busy_i = 2'b01; instr_gnt_i = 1'b1;
    settle();
    total++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h8C) $display("FAIL throttle_issue got r=%b a=%h exp 1 0000008c", instr_req_o, instr_addr_o); else passed++;
    tick();
    total++; if (instr_req_o !== 1'b0) $display("FAIL throttle_one got %b exp 0", instr_req_o); else passed++;
    fifo_busy_i = 2'b00; req_i = 1'b0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'hD000_008C;
    settle();
    total++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== 32'hD000_008C) $display("FAIL throttle_push got v=%b d=%h exp 1 d000008c", fifo_valid_o, fifo_rdata_o); else passed++;
    tick();
    instr_rvalid_i = 1'b0;
  endtask

  task automatic test_branch_inflight();
    req_i = 1'b1; instr_gnt_i = 1'b1;
    settle();
    total++; if (instr_addr_o !== 32'h90) $display("FAIL bif_addr0 got %h exp 00000090", instr_addr_o); else passed++;
    tick();
    total++; if (instr_addr_o !== 32'h94) $display("FAIL bif_addr1 got %h exp 00000094", instr_addr_o); else passed++;
    tick();
    branch_i = 1'b1; addr_i = 32'h200;
    settle();
    total++; if (instr_req_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL bif_full got r=%b b=%b exp 0 1", instr_req_o, busy_o); else passed++;
    total++; if (fifo_clear_o !== 1'b1 || fifo_addr_o !== 32'h200) $display("FAIL bif_clear got c=%b a=%h exp 1 00000200", fifo_clear_o, fifo_addr_o); else passed++;
    tick();
    branch_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hBAD0_0090;
    settle();
    total++; if (fifo_valid_o !== 1'b0 || instr_req_o !== 1'b0) $display("FAIL bif_drop0 got v=%b r=%b exp 0 0", fifo_valid_o, instr_req_o); else passed++;
    tick();
    instr_rdata_i = 32'hBAD0_0094;
    settle();
    total++; if (fifo_valid_o !== 1'b0) $display("FAIL bif_drop1 got %b exp 0", fifo_valid_o); else passed++;
    total++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) $display("FAIL bif_newaddr got r=%b a=%h exp 1 00000200", instr_req_o, instr_addr_o); else passed++;
    tick();
    req_i = 1'b0; instr_gnt_i = 1'b0; instr_rdata_i = 32'hD000_0200;
    settle();
    total++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== 32'hD000_0200) $display("FAIL bif_push got v=%b d=%h exp 1 d0000200", fifo_valid_o, fifo_rdata_o); else passed++;
    tick();
    instr_rvalid_i = 1'b0;
  endtask

  task automatic test_branch_wait_gnt();
    req_i = 1'b1; instr_gnt_i = 1'b0; branch_i = 1'b1; addr_i = 32'h84;
    settle();
    total++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h84) $display("FAIL bwg_issue got r=%b a=%h exp 1 00000084", instr_req_o, instr_addr_o); else passed++;
    tick();
    addr_i = 32'h400;
    settle();
    total++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h84) $display("FAIL bwg_hold0 got r=%b a=%h exp 1 00000084", instr_req_o, instr_addr_o); else passed++;
    tick();
    branch_i = 1'b0; instr_gnt_i = 1'b1;
    settle();
    total++; if (instr_addr_o !== 32'h84) $display("FAIL bwg_hold1 got %h exp 00000084", instr_addr_o); else passed++;
    tick();
    req_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hBAD0_0084;
    settle();
    total++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h400) $display("FAIL bwg_target got r=%b a=%h exp 1 00000400", instr_req_o, instr_addr_o); else passed++;
    total++; if (fifo_valid_o !== 1'b0) $display("FAIL bwg_drop got %b exp 0", fifo_valid_o); else passed++;
    tick();
    instr_gnt_i = 1'b0; instr_rdata_i = 32'hD000_0400;
    settle();
    total++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== 32'hD000_0400) $display("FAIL bwg_push got v=%b d=%h exp 1 d0000400", fifo_valid_o, fifo_rdata_o); else passed++;
    total++; if (instr_req_o !== 1'b0) $display("FAIL bwg_idle got %b exp 0", instr_req_o); else passed++;
    tick();
    instr_rvalid_i = 1'b0;
  endtask

  task automatic test_pcc_bounds();
    pcc_base_i = 32'h100; pcc_top_i = 33'h106;
    req_i = 1'b1; instr_gnt_i = 1'b1; branch_i = 1'b1; addr_i = 32'h100;
    settle();
    total++; if (instr_addr_o !== 32'h100) $display("FAIL pcc_addr0 got %h exp 00000100", instr_addr_o); else passed++;
    tick();
    branch_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hC000_0100;
    settle();
    total++; if (fifo_valid_o !== 1'b1 || fifo_cheri_lower_err_o !== 1'b0 || fifo_cheri_upper_err_o !== 1'b0) $display("FAIL pcc_w0 got v=%b l=%b u=%b exp 1 0 0", fifo_valid_o, fifo_cheri_lower_err_o, fifo_cheri_upper_err_o); else passed++;
    tick();
    req_i = 1'b0; instr_gnt_i = 1'b0; instr_err_i = 1'b1; instr_rdata_i = 32'hC000_0104;
    settle();
    total++; if (fifo_valid_o !== 1'b1 || fifo_cheri_lower_err_o !== 1'b0 || fifo_cheri_upper_err_o !== 1'b1) $display("FAIL pcc_w1 got v=%b l=%b u=%b exp 1 0 1", fifo_valid_o, fifo_cheri_lower_err_o, fifo_cheri_upper_err_o); else passed++;
    total++; if (fifo_err_o !== 1'b1) $display("FAIL pcc_buserr got %b exp 1", fifo_err_o); else passed++;
    tick();
    instr_rvalid_i = 1'b0; instr_err_i = 1'b0;
    pcc_base_i = '0; pcc_top_i = 33'h1_0000_0000;
  endtask

  task automatic test_wrap_reset();
    req_i = 1'b1; instr_gnt_i = 1'b1; branch_i = 1'b1; addr_i = 32'hFFFF_FFFC;
    settle();
    total++; if (instr_addr_o !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0 got %h exp fffffffc", instr_addr_o); else passed++;
    tick();
    branch_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hD0FF_FFFC;
    settle();
    total++; if (instr_addr_o !== 32'h0) $display("FAIL wrap_addr1 got %h exp 00000000", instr_addr_o); else passed++;
    total++; if (fifo_valid_o !== 1'b1 || fifo_cheri_upper_err_o !== 1'b0) $display("FAIL wrap_push got v=%b u=%b exp 1 0", fifo_valid_o, fifo_cheri_upper_err_o); else passed++;
    tick();
    instr_gnt_i = 1'b0; instr_rdata_i = 32'hD000_0000;
    settle();
    total++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h4) $display("FAIL wrap_addr2 got r=%b a=%h exp 1 00000004", instr_req_o, instr_addr_o); else passed++;
    tick();
    instr_rvalid_i = 1'b0; req_i = 1'b0;
    settle();
    total++; if (busy_o !== 1'b1 || instr_req_o !== 1'b1) $display("FAIL wrap_held got b=%b r=%b exp 1 1", busy_o, instr_req_o); else passed++;
    instr_gnt_i = 1'b1; rst_ni = 1'b0;
    settle();
    total++; if (instr_req_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL rst_mid got r=%b b=%b exp 0 0", instr_req_o, busy_o); else passed++;
    tick();
    rst_ni = 1'b1; instr_gnt_i = 1'b0; req_i = 1'b1;
    settle();
    total++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) $display("FAIL rst_addr got r=%b a=%h exp 1 00000000", instr_req_o, instr_addr_o); else passed++;
    tick();
    req_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_throttle();
    test_branch_inflight();
    test_branch_wait_gnt();
    test_pcc_bounds();
    test_wrap_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
